// File: rtl/pool_pkg.sv
// Shared definitions for the pooling job scheduler: engine PLTY codes, job sizes,
// scheduler state encoding and a width helper for counters and indices.
package pool_pkg;

  typedef enum logic [1:0] {
    PLTY_NOP  = 2'b00,
    PLTY_AVG1 = 2'b01,
    PLTY_AVG2 = 2'b10,
    PLTY_SUM  = 2'b11
  } plty_e;

  localparam int P_TYPE1_LEN = 325;   // 25x13 input map
  localparam int P_TYPE2_LEN = 4000;  // 100x40 input map
  localparam int P_TYPE1_OUT = 1;
  localparam int P_TYPE2_OUT = 325;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_STRT  = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } sched_state_e;

  // Bits needed to index n items (or hold 0..n-1); never less than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import pool_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW   = width_for(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pool_job_scheduler.sv
// Round-robin scheduler sharing one average-pooling engine among N_REQ channels:
// grants a job, starts the engine, muxes the granted input stream, counts outputs.
module pool_job_scheduler
  import pool_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int INWIDTH   = 16,
  parameter int TYPE1_LEN = P_TYPE1_LEN,
  parameter int TYPE2_LEN = P_TYPE2_LEN,
  parameter int TYPE1_OUT = P_TYPE1_OUT,
  parameter int TYPE2_OUT = P_TYPE2_OUT,
  parameter int TMO_CYC   = 8192,
  localparam int SW       = width_for(N_REQ)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     EN,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [2*N_REQ-1:0]       REQ_PLTY,
  input  logic [INWIDTH*N_REQ-1:0] REQ_DIN,
  input  logic [N_REQ-1:0]         REQ_DIN_VLD,
  output logic [N_REQ-1:0]         REQ_DIN_RDY,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         DONE,
  output logic [N_REQ-1:0]         ERR,
  output logic                     PL_START,
  output logic [1:0]               PL_PLTY,
  output logic [INWIDTH-1:0]       PL_DIN,
  output logic                     PL_DIN_VLD,
  input  logic                     PL_DIN_RDY,
  input  logic                     PL_DOUT_VLD,
  input  logic                     PL_DOUT_RDY,
  output logic [SW-1:0]            OUT_SRC,
  output sched_state_e             DBG_STATE
);

  localparam int INW  = width_for(TYPE2_LEN + 1);
  localparam int OUTW = width_for(TYPE2_OUT + 1);
  localparam int TW   = width_for(TMO_CYC);

  sched_state_e     state_q, state_d;
  logic [SW-1:0]    ptr_q, sel_q;
  logic [N_REQ-1:0] gnt_q;
  logic [1:0]       plty_q;
  logic             err_q;
  logic [INW-1:0]   in_cnt_q;
  logic [OUTW-1:0]  out_cnt_q;
  logic [TW-1:0]    tmo_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [SW-1:0]    arb_idx;
  logic             arb_any;
  logic [1:0]       arb_plty;
  logic             arb_bad;
  logic             in_open, din_xfer, dout_xfer;
  logic             feed_last, drain_done, drain_tmo;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Handshake: a word moves on any cycle where its valid and ready are both high;
  // valid never waits on ready. Lane ready/valid are pure functions of state and inputs.
  assign arb_plty   = REQ_PLTY[2*int'(arb_idx) +: 2];
  assign arb_bad    = (arb_plty == PLTY_NOP) || (arb_plty == PLTY_SUM);
  assign in_open    = (in_cnt_q != '0);
  assign din_xfer   = PL_DIN_VLD & PL_DIN_RDY;
  // Output words are counted from FEED on, so a streaming engine's early outputs are not lost.
  assign dout_xfer  = PL_DOUT_VLD & PL_DOUT_RDY &
                      ((state_q == ST_FEED) || (state_q == ST_DRAIN));
  assign feed_last  = din_xfer && (in_cnt_q == INW'(1));
  assign drain_done = (out_cnt_q == '0) || (dout_xfer && (out_cnt_q == OUTW'(1)));
  assign drain_tmo  = !dout_xfer && (tmo_q == TW'(TMO_CYC - 1));
  assign DBG_STATE  = state_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else if (EN) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|REQ) state_d = ST_ARB;
      ST_ARB: begin
        if (!arb_any)     state_d = ST_IDLE;
        else if (arb_bad) state_d = ST_FIN;
        else              state_d = ST_STRT;
      end
      ST_STRT:  state_d = ST_FEED;
      ST_FEED:  if (feed_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done || drain_tmo) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      plty_q    <= '0;
      err_q     <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      tmo_q     <= '0;
    end else if (EN) begin
      case (state_q)
        ST_ARB: begin
          sel_q  <= arb_idx;
          gnt_q  <= arb_gnt;
          plty_q <= arb_plty;
          err_q  <= arb_bad;
          tmo_q  <= '0;
          if (arb_plty == PLTY_AVG2) begin
            in_cnt_q  <= INW'(TYPE2_LEN);
            out_cnt_q <= OUTW'(TYPE2_OUT);
          end else begin
            in_cnt_q  <= INW'(TYPE1_LEN);
            out_cnt_q <= OUTW'(TYPE1_OUT);
          end
        end
        ST_FEED: begin
          if (din_xfer) in_cnt_q <= in_cnt_q - INW'(1);
          if (dout_xfer && (out_cnt_q != '0)) out_cnt_q <= out_cnt_q - OUTW'(1);
        end
        ST_DRAIN: begin
          if (dout_xfer) begin
            tmo_q <= '0;
            if (out_cnt_q != '0) out_cnt_q <= out_cnt_q - OUTW'(1);
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
          if (!drain_done && drain_tmo) err_q <= 1'b1;
        end
        ST_FIN: begin
          ptr_q <= (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + SW'(1);
          gnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    GNT         = '0;
    OUT_SRC     = '0;
    DONE        = '0;
    ERR         = '0;
    PL_START    = 1'b0;
    PL_PLTY     = '0;
    PL_DIN      = '0;
    PL_DIN_VLD  = 1'b0;
    REQ_DIN_RDY = '0;
    case (state_q)
      ST_ARB: begin
        GNT     = arb_gnt;
        OUT_SRC = arb_idx;
      end
      ST_STRT: begin
        GNT      = gnt_q;
        OUT_SRC  = sel_q;
        PL_START = 1'b1;
        PL_PLTY  = plty_q;
      end
      ST_FEED: begin
        GNT                = gnt_q;
        OUT_SRC            = sel_q;
        PL_DIN             = REQ_DIN[int'(sel_q)*INWIDTH +: INWIDTH];
        PL_DIN_VLD         = REQ_DIN_VLD[sel_q] & in_open;
        REQ_DIN_RDY[sel_q] = PL_DIN_RDY & in_open;
      end
      ST_DRAIN: begin
        GNT     = gnt_q;
        OUT_SRC = sel_q;
      end
      ST_FIN: begin
        DONE = err_q ? '0 : gnt_q;
        ERR  = err_q ? gnt_q : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pool_job_scheduler.sv
// Directed bench for pool_job_scheduler: normal, illegal-PLTY, throttled, timeout,
// four-way round-robin and mid-job reset scenarios against hand-computed values.
module tb_pool_job_scheduler;
  import pool_pkg::*;

  localparam int TMO = 8192;

  logic         CLK;
  logic         RESET;
  logic         EN;
  logic [3:0]   REQ;
  logic [7:0]   REQ_PLTY;
  logic [63:0]  REQ_DIN;
  logic [3:0]   REQ_DIN_VLD;
  logic [3:0]   REQ_DIN_RDY;
  logic [3:0]   GNT;
  logic [3:0]   DONE;
  logic [3:0]   ERR;
  logic         PL_START;
  logic [1:0]   PL_PLTY;
  logic [15:0]  PL_DIN;
  logic         PL_DIN_VLD;
  logic         PL_DIN_RDY;
  logic         PL_DOUT_VLD;
  logic         PL_DOUT_RDY;
  logic [1:0]   OUT_SRC;
  sched_state_e dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  pool_job_scheduler dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .EN          (EN),
    .REQ         (REQ),
    .REQ_PLTY    (REQ_PLTY),
    .REQ_DIN     (REQ_DIN),
    .REQ_DIN_VLD (REQ_DIN_VLD),
    .REQ_DIN_RDY (REQ_DIN_RDY),
    .GNT         (GNT),
    .DONE        (DONE),
    .ERR         (ERR),
    .PL_START    (PL_START),
    .PL_PLTY     (PL_PLTY),
    .PL_DIN      (PL_DIN),
    .PL_DIN_VLD  (PL_DIN_VLD),
    .PL_DIN_RDY  (PL_DIN_RDY),
    .PL_DOUT_VLD (PL_DOUT_VLD),
    .PL_DOUT_RDY (PL_DOUT_RDY),
    .OUT_SRC     (OUT_SRC),
    .DBG_STATE   (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input int lane, input int k);
    return 16'(lane * 4096 + (k % 4096));
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},   GNT, 4'b0000);
    chk({tag, "_done"},  DONE, 4'b0000);
    chk({tag, "_err"},   ERR, 4'b0000);
    chk({tag, "_start"}, PL_START, 1'b0);
    chk({tag, "_plty"},  PL_PLTY, 2'b00);
    chk({tag, "_vld"},   PL_DIN_VLD, 1'b0);
    chk({tag, "_din"},   PL_DIN, 16'h0000);
    chk({tag, "_rdy"},   REQ_DIN_RDY, 4'b0000);
    chk({tag, "_src"},   OUT_SRC, 2'd0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // driver: run one granted job; returns in the FIN cycle (or after abort_at input words)
  task automatic do_job(input int lane, input logic [1:0] plty, input int exp_lat,
                        input int n_in, input int n_out, input int n_stop,
                        input bit rnd, input int abort_at);
    logic [3:0] lm;
    int cyc, xf, outs, bad_data, bad_hs, bad_lane, early, idle;
    lm = 4'b0001 << lane;
    REQ_DIN_VLD = 4'b0000;
    PL_DIN_RDY  = 1'b0;
    PL_DOUT_VLD = 1'b0;
    PL_DOUT_RDY = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK); #1;
      cyc++;
    end while (!PL_START && cyc < 12);
    chk("start_lat", cyc, exp_lat);
    chk("start_plty", PL_PLTY, plty);
    chk("start_gnt", GNT, lm);
    chk("start_src", OUT_SRC, lane);

    xf = 0; cyc = 0; bad_data = 0; bad_hs = 0; bad_lane = 0;
    while (xf < n_in && cyc < n_in * 8 + 20 && !(abort_at != 0 && xf == abort_at)) begin
      @(negedge CLK);
      for (int l = 0; l < 4; l++) REQ_DIN[l*16 +: 16] = word(l, xf);
      REQ_DIN_VLD = rnd ? 4'($urandom_range(0, 15)) : 4'b1111;
      PL_DIN_RDY  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (REQ_DIN_RDY !== (PL_DIN_RDY ? lm : 4'b0000)) bad_hs++;
      if (PL_DIN_VLD !== REQ_DIN_VLD[lane]) bad_hs++;
      if (GNT !== lm || OUT_SRC !== 2'(lane)) bad_lane++;
      if (PL_DIN_VLD && PL_DIN_RDY) begin
        if (PL_DIN !== word(lane, xf)) bad_data++;
        xf++;
      end
      cyc++;
    end
    chk("feed_hs_errs", bad_hs, 0);
    chk("feed_lane_errs", bad_lane, 0);
    chk("feed_data_errs", bad_data, 0);
    if (abort_at != 0) begin
      chk("abort_words", xf, abort_at);
      return;
    end
    chk("in_xfers", xf, n_in);

    @(negedge CLK);
    REQ_DIN_VLD = 4'b1111;
    PL_DIN_RDY  = 1'b1;
    #1;
    chk("after_feed_vld", PL_DIN_VLD, 1'b0);
    chk("after_feed_rdy", REQ_DIN_RDY, 4'b0000);
    chk("drain_src", OUT_SRC, lane);

    outs = 0; cyc = 0; early = 0;
    while (outs < n_stop && cyc < n_stop * 8 + 20) begin
      @(negedge CLK);
      PL_DOUT_VLD = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      PL_DOUT_RDY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (DONE != 4'b0000 || ERR != 4'b0000) early++;
      if (PL_DOUT_VLD && PL_DOUT_RDY) outs++;
      cyc++;
    end
    chk("out_words", outs, n_stop);
    chk("no_early_end", early, 0);

    @(negedge CLK);
    PL_DOUT_VLD = 1'b0;
    #1;
    if (n_stop == n_out) begin
      chk("done", DONE, lm);
      chk("done_err", ERR, 4'b0000);
      chk("fin_gnt", GNT, 4'b0000);
    end else begin
      idle = 0;
      while (ERR == 4'b0000 && DONE == 4'b0000 && idle < TMO + 20) begin
        idle++;
        @(negedge CLK); #1;
      end
      chk("tmo_idle_cycles", idle, TMO);
      chk("tmo_err", ERR, lm);
      chk("tmo_done", DONE, 4'b0000);
      chk("tmo_gnt", GNT, 4'b0000);
    end
  endtask

  initial begin
    int cyc, st, n;
    RESET = 1'b1; EN = 1'b1; REQ = '0; REQ_PLTY = '0; REQ_DIN = '0;
    REQ_DIN_VLD = 4'b1111; PL_DIN_RDY = 1'b1; PL_DOUT_VLD = 1'b0; PL_DOUT_RDY = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk_idle("reset");
    RESET = 1'b0;

    // clock enable low: request must not be picked up
    EN = 1'b0; REQ = 4'b0001; REQ_PLTY = 8'b00_00_00_01;
    repeat (4) @(negedge CLK);
    #1;
    chk("en0_gnt", GNT, 4'b0000);
    chk("en0_state", dbg_state, ST_IDLE);
    EN = 1'b1;

    // T1: single type-1 job on lane 0
    do_job(0, 2'b01, 2, 325, 1, 1, 1'b0, 0);
    REQ = 4'b0000; RESET = 1'b1;
    @(negedge CLK); #1;
    chk_idle("rst2");
    RESET = 1'b0;

    // T3: illegal PLTY on lane 0, lane 1 also waiting
    REQ = 4'b0011; REQ_PLTY = 8'b00_00_01_11;
    cyc = 0; st = 0;
    do begin
      @(negedge CLK); #1;
      cyc++;
      if (PL_START) st = 1;
    end while (ERR == 4'b0000 && cyc < 10);
    chk("t3_err_lat", cyc, 2);
    chk("t3_err", ERR, 4'b0001);
    chk("t3_done", DONE, 4'b0000);
    chk("t3_no_start", st, 0);
    // pointer moved past lane 0, so lane 1 wins although lane 0 still requests
    do_job(1, 2'b01, 3, 325, 1, 1, 1'b0, 0);
    REQ = 4'b0100; REQ_PLTY = 8'b00_01_00_00;

    // T4: random valid / throttled ready on lane 2
    do_job(2, 2'b01, 3, 325, 1, 1, 1'b1, 0);
    REQ = 4'b1000; REQ_PLTY = 8'b10_00_00_00;

    // T5: type-2 job on lane 3, engine stalls after 100 outputs
    do_job(3, 2'b10, 3, 4000, 325, 100, 1'b0, 0);
    REQ = 4'b1111; REQ_PLTY = 8'b10_10_10_10;

    // T2: all four lanes, type-2, served in order 0,1,2,3
    do_job(0, 2'b10, 3, 4000, 325, 325, 1'b0, 0);
    REQ = 4'b1110;
    do_job(1, 2'b10, 3, 4000, 325, 325, 1'b0, 0);
    REQ = 4'b1100;
    do_job(2, 2'b10, 3, 4000, 325, 325, 1'b0, 0);
    REQ = 4'b1000;
    do_job(3, 2'b10, 3, 4000, 325, 325, 1'b0, 0);
    REQ = 4'b0001;

    // T6: reset in the middle of feeding
    do_job(0, 2'b10, 3, 4000, 325, 325, 1'b0, 1000);
    RESET = 1'b1; REQ = 4'b0000;
    @(negedge CLK); #1;
    chk_idle("t6_rst");
    RESET = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge CLK); #1;
      if (DONE != 4'b0000 || ERR != 4'b0000 || GNT != 4'b0000) n++;
    end
    chk("t6_quiet", n, 0);
    REQ = 4'b0010; REQ_PLTY = 8'b00_00_01_00;
    do_job(1, 2'b01, 2, 325, 1, 1, 1'b0, 0);
    REQ = 4'b0000;
    @(negedge CLK); #1;
    chk("final_state", dbg_state, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
